// File: rtl/mem_arb_pkg.sv
// Shared encodings and default parameters for the MCB command-port arbiter.
// The optional grant/abort statistics are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

  localparam int unsigned RD_LVL_W_DEF      = 7;
  localparam int unsigned RD_URGENT_DEF     = 16;
  localparam int unsigned MAX_RD_STREAK_DEF = 4;
  localparam int unsigned GAP_CYC_DEF       = 2;
  localparam int unsigned TIMEOUT_DEF       = 4096;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GNT_WR = 2'b01;
  localparam logic [1:0] GNT_RD = 2'b10;
  localparam logic [1:0] GAP    = 2'b11;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_RD   = 2'b01;
  localparam logic [1:0] ARB_WR   = 2'b10;

  localparam logic [1:0] ID_NONE = 2'b00;
  localparam logic [1:0] ID_WR0  = 2'b01;
  localparam logic [1:0] ID_WR1  = 2'b10;
  localparam logic [1:0] ID_RD   = 2'b11;

  // Grant id for a writer index.
  function automatic logic [1:0] wr_id(input logic idx);
    return idx ? ID_WR1 : ID_WR0;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: prefers the writer that did not win last time.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = last;
    if (req[~last]) pick = ~last;
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter for the single MCB command/write port shared by two line writers and
// the display reader. Build with MEM_ARB_STATS_EN to add grant/abort counters.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LVL_W      = RD_LVL_W_DEF,
  parameter int unsigned RD_URGENT     = RD_URGENT_DEF,
  parameter int unsigned MAX_RD_STREAK = MAX_RD_STREAK_DEF,
  parameter int unsigned GAP_CYC       = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                cmd_clk,
  input  logic                mem_rst_n,
  input  logic                calib_done,
  input  logic [1:0]          wr_req,
  input  logic [1:0]          wr_done,
  input  logic                rd_req,
  input  logic                rd_done,
  input  logic [RD_LVL_W-1:0] rd_fifo_lvl,
  output logic [1:0]          wr_probe,
  output logic                rd_probe,
  output logic [1:0]          arb_state,
  output logic                timeout_err,
  output logic [7:0]          debug
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [63:0]         stat_bus
`endif
);

  localparam int unsigned STREAK_W = ($clog2(MAX_RD_STREAK + 1) > 2) ? $clog2(MAX_RD_STREAK + 1) : 2;
  localparam int unsigned WDOG_W   = $clog2(TIMEOUT);
  localparam int unsigned GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  logic [1:0]          state, state_nxt;
  logic [1:0]          gnt_id, gnt_nxt;
  logic                last_wr, last_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic [WDOG_W-1:0]   wdog, wdog_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic                terr_nxt;
  logic [1:0]          wr_probe_nxt;
  logic                rd_probe_nxt;
  logic [1:0]          arb_nxt;
  logic                wr_grant, rd_grant, abort;
  logic                rr_valid, rr_pick;
  logic                rd_urgent, streak_full, gnt_done, gap_last;

  mem_arb_rr u_rr (
    .req   (wr_req),
    .last  (last_wr),
    .valid (rr_valid),
    .pick  (rr_pick)
  );

  // Next-state, grant bookkeeping and next output values.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_id;
    last_nxt   = last_wr;
    streak_nxt = streak;
    wdog_nxt   = wdog;
    gap_nxt    = gap_cnt;
    wr_grant   = 1'b0;
    rd_grant   = 1'b0;
    abort      = 1'b0;

    rd_urgent   = rd_req && (32'(rd_fifo_lvl) < RD_URGENT);
    streak_full = (streak == STREAK_W'(MAX_RD_STREAK));
    gnt_done    = ((gnt_id == ID_WR0) && wr_done[0]) ||
                  ((gnt_id == ID_WR1) && wr_done[1]) ||
                  ((gnt_id == ID_RD)  && rd_done);
    gap_last    = (GAP_CYC <= 1) || (gap_cnt == GAP_W'(GAP_CYC - 1));

    if (!calib_done) begin
      state_nxt = IDLE;
      gnt_nxt   = ID_NONE;
      wdog_nxt  = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_urgent && !(streak_full && rr_valid)) rd_grant = 1'b1;
          else if (rr_valid)                          wr_grant = 1'b1;
          else if (rd_req)                            rd_grant = 1'b1;
        end
        GNT_WR, GNT_RD: begin
          if (gnt_done || (wdog == WDOG_W'(TIMEOUT - 1))) begin
            abort     = !gnt_done;
            state_nxt = GAP;
            gnt_nxt   = ID_NONE;
            gap_nxt   = '0;
          end else begin
            wdog_nxt = wdog + WDOG_W'(1);
          end
        end
        default: begin
          if (gap_last) state_nxt = IDLE;
          else          gap_nxt   = gap_cnt + GAP_W'(1);
        end
      endcase

      if (rd_grant) begin
        state_nxt = GNT_RD;
        gnt_nxt   = ID_RD;
        wdog_nxt  = '0;
        if (rr_valid && !streak_full) streak_nxt = streak + STREAK_W'(1);
      end
      if (wr_grant) begin
        state_nxt  = GNT_WR;
        gnt_nxt    = wr_id(rr_pick);
        last_nxt   = rr_pick;
        streak_nxt = '0;
        wdog_nxt   = '0;
      end
    end

    terr_nxt     = timeout_err | abort;
    wr_probe_nxt = {gnt_nxt == ID_WR1, gnt_nxt == ID_WR0};
    rd_probe_nxt = (gnt_nxt == ID_RD);
    arb_nxt      = (state_nxt == GNT_WR) ? ARB_WR :
                   (state_nxt == GNT_RD) ? ARB_RD : ARB_IDLE;
  end

  always_ff @(posedge cmd_clk) begin
    if (!mem_rst_n) begin
      state       <= IDLE;
      gnt_id      <= ID_NONE;
      last_wr     <= 1'b1;
      streak      <= '0;
      wdog        <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
      wr_probe    <= 2'b00;
      rd_probe    <= 1'b0;
      arb_state   <= ARB_IDLE;
    end else begin
      state       <= state_nxt;
      gnt_id      <= gnt_nxt;
      last_wr     <= last_nxt;
      streak      <= streak_nxt;
      wdog        <= wdog_nxt;
      gap_cnt     <= gap_nxt;
      timeout_err <= terr_nxt;
      wr_probe    <= wr_probe_nxt;
      rd_probe    <= rd_probe_nxt;
      arb_state   <= arb_nxt;
    end
  end

  assign debug = {timeout_err, last_wr, streak[1:0], gnt_id, state};

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt_wr0, cnt_wr1, cnt_rd, cnt_abort;

  // Wrapping grant and abort counters.
  always_ff @(posedge cmd_clk) begin
    if (!mem_rst_n) begin
      cnt_wr0   <= '0;
      cnt_wr1   <= '0;
      cnt_rd    <= '0;
      cnt_abort <= '0;
    end else begin
      if (wr_grant && !rr_pick) cnt_wr0   <= cnt_wr0 + 16'(1);
      if (wr_grant && rr_pick)  cnt_wr1   <= cnt_wr1 + 16'(1);
      if (rd_grant)             cnt_rd    <= cnt_rd + 16'(1);
      if (abort)                cnt_abort <= cnt_abort + 16'(1);
    end
  end

  assign stat_bus = {cnt_abort, cnt_rd, cnt_wr1, cnt_wr0};
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus random traffic
// compared every cycle against an owner/cool-down reference model.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int unsigned LVL_W = 7;
  localparam int unsigned URG   = 16;
  localparam int unsigned MAXS  = 4;
  localparam int unsigned GAPC  = 2;
  localparam int unsigned TMO   = 4096;

  logic             cmd_clk = 1'b0;
  logic             mem_rst_n, calib_done, rd_req, rd_done;
  logic [1:0]       wr_req, wr_done;
  logic [LVL_W-1:0] rd_fifo_lvl;
  logic [1:0]       wr_probe, arb_state;
  logic             rd_probe, timeout_err;
  logic [7:0]       debug;
`ifdef MEM_ARB_STATS_EN
  logic [63:0]      stat_bus;
`endif

  always #5 cmd_clk = ~cmd_clk;

  mem_arb #(
    .RD_LVL_W(LVL_W), .RD_URGENT(URG), .MAX_RD_STREAK(MAXS),
    .GAP_CYC(GAPC), .TIMEOUT(TMO)
  ) dut (
    .cmd_clk     (cmd_clk),
    .mem_rst_n   (mem_rst_n),
    .calib_done  (calib_done),
    .wr_req      (wr_req),
    .wr_done     (wr_done),
    .rd_req      (rd_req),
    .rd_done     (rd_done),
    .rd_fifo_lvl (rd_fifo_lvl),
    .wr_probe    (wr_probe),
    .rd_probe    (rd_probe),
    .arb_state   (arb_state),
    .timeout_err (timeout_err),
    .debug       (debug)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_bus    (stat_bus)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the port, how long, and the cool-down before the next decision.
  int m_owner;   // -1 none, 0/1 writer, 2 reader
  int m_held;
  int m_cool;
  int m_last;
  int m_streak;
  bit m_terr;
  int m_cnt [4]; // wr0, wr1, rd, abort

  int starve_exp [6] = '{2, 2, 2, 2, 0, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void release_port();
    m_owner = -1;
    m_cool  = (GAPC == 0) ? 1 : int'(GAPC);
  endfunction

  function automatic void model_edge();
    bit any_w, urgent, done_o;
    int w;
    if (!mem_rst_n) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_last = 1; m_streak = 0; m_terr = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      return;
    end
    if (!calib_done) begin
      m_owner = -1; m_cool = 0;
      return;
    end
    if (m_owner >= 0) begin
      done_o = (m_owner == 2) ? rd_done : wr_done[m_owner];
      if (done_o) release_port();
      else if (m_held == int'(TMO) - 1) begin
        release_port();
        m_terr = 1;
        m_cnt[3]++;
      end else m_held++;
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      any_w  = (wr_req != 2'b00);
      urgent = rd_req && (int'(rd_fifo_lvl) < int'(URG));
      if ((urgent && !(m_streak == int'(MAXS) && any_w)) || (!any_w && rd_req)) begin
        m_owner = 2; m_held = 0; m_cnt[2]++;
        if (any_w && m_streak < int'(MAXS)) m_streak++;
      end else if (any_w) begin
        w = wr_req[1 - m_last] ? 1 - m_last : m_last;
        m_owner = w; m_last = w; m_held = 0; m_streak = 0; m_cnt[w]++;
      end
    end
  endfunction

  task automatic check_outputs();
    logic [1:0] e_wr, e_arb;
    e_wr  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_arb = (m_owner == 2) ? 2'b01 : (m_owner >= 0) ? 2'b10 : 2'b00;
    chk("wr_probe", 32'(wr_probe), 32'(e_wr));
    chk("rd_probe", 32'(rd_probe), 32'(m_owner == 2));
    chk("arb_state", 32'(arb_state), 32'(e_arb));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("debug_hi", 32'(debug[7:4]), 32'({m_terr, m_last[0], m_streak[1:0]}));
  endtask

  task automatic step();
    @(posedge cmd_clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic reset_dut();
    mem_rst_n = 1'b0; calib_done = 1'b0; wr_req = 2'b00; wr_done = 2'b00;
    rd_req = 1'b0; rd_done = 1'b0; rd_fifo_lvl = 7'd64;
    step(); step();
    mem_rst_n = 1'b1;
    calib_done = 1'b1;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 50; i++) begin
      if ((wr_probe != 2'b00) || rd_probe) return;
      step();
    end
    chk("grant_wait", 32'((wr_probe != 2'b00) || rd_probe), 32'd1);
  endtask

  function automatic int gcode();
    return rd_probe ? 2 : (wr_probe == 2'b01) ? 0 : (wr_probe == 2'b10) ? 1 : -1;
  endfunction

  initial begin
    int cnt;

    // Calibration gate with every requester active.
    reset_dut();
    calib_done = 1'b0; wr_req = 2'b11; rd_req = 1'b1;
    repeat (10) step();
    chk("calib_low_probe", 32'({wr_probe, rd_probe, arb_state}), 32'd0);
    calib_done = 1'b1;
    step();
    chk("calib_first_wr", 32'(wr_probe), 32'h1);
    chk("calib_first_arb", 32'(arb_state), 32'h2);

    // Round-robin between writers, done five cycles after each probe.
    reset_dut();
    wr_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_grant();
      chk("rr_order", 32'(gcode()), 32'(g % 2));
      repeat (4) step();
      wr_done = wr_probe;
      step();
      wr_done = 2'b00;
    end

    // Urgent reads are capped while a write waits.
    reset_dut();
    rd_fifo_lvl = 7'd3; rd_req = 1'b1; wr_req = 2'b01;
    for (int g = 0; g < 6; g++) begin
      wait_grant();
      chk("starve_order", 32'(gcode()), 32'(starve_exp[g]));
      rd_done = rd_probe; wr_done = wr_probe;
      step();
      rd_done = 1'b0; wr_done = 2'b00;
    end

    // Watchdog abort of writer 1.
    reset_dut();
    wr_req = 2'b10;
    wait_grant();
    wr_req = 2'b00;
    cnt = 0;
    while (wr_probe[1] && cnt < 5000) begin
      cnt++;
      step();
    end
    chk("tmo_len", 32'(cnt), 32'(TMO));
    chk("tmo_err", 32'(timeout_err), 32'd1);
`ifdef MEM_ARB_STATS_EN
    chk("stat_wr1", 32'(stat_bus[31:16]), 32'd1);
    chk("stat_abort", 32'(stat_bus[63:48]), 32'd1);
`endif
    wr_req = 2'b01;
    repeat (12) step();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // done arriving on the exact timeout cycle wins.
    reset_dut();
    wr_req = 2'b10;
    wait_grant();
    wr_req = 2'b00;
    repeat (TMO - 1) step();
    chk("tmo_edge_held", 32'(wr_probe), 32'h2);
    wr_done = 2'b10;
    step();
    wr_done = 2'b00;
    chk("tmo_edge_err", 32'(timeout_err), 32'd0);
    chk("tmo_edge_probe", 32'(wr_probe), 32'd0);

    // done from the other writer is ignored.
    reset_dut();
    wr_req = 2'b01;
    wait_grant();
    wr_req = 2'b00; wr_done = 2'b10;
    repeat (3) step();
    chk("spurious_done", 32'(wr_probe), 32'h1);
    wr_done = 2'b01;
    step();
    wr_done = 2'b00;

    // Calibration loss in the middle of a read grant.
    reset_dut();
    rd_req = 1'b1;
    wait_grant();
    chk("calib_rd_gnt", 32'(rd_probe), 32'd1);
    calib_done = 1'b0;
    step();
    chk("calib_drop_out", 32'({wr_probe, rd_probe, arb_state}), 32'd0);
    chk("calib_drop_state", 32'(debug[1:0]), 32'(IDLE));
    calib_done = 1'b1; rd_req = 1'b0;

    // Random traffic against the model.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      calib_done  = ($urandom_range(99) < 97);
      wr_req      = 2'($urandom);
      rd_req      = 1'($urandom);
      rd_fifo_lvl = 7'($urandom);
      wr_done     = {($urandom_range(9) < 3), ($urandom_range(9) < 3)};
      rd_done     = ($urandom_range(9) < 3);
      step();
    end
`ifdef MEM_ARB_STATS_EN
    chk("stat_rnd_wr0", 32'(stat_bus[15:0]), 32'(m_cnt[0] % 65536));
    chk("stat_rnd_wr1", 32'(stat_bus[31:16]), 32'(m_cnt[1] % 65536));
    chk("stat_rnd_rd", 32'(stat_bus[47:32]), 32'(m_cnt[2] % 65536));
    chk("stat_rnd_abort", 32'(stat_bus[63:48]), 32'(m_cnt[3] % 65536));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
